// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through instruction queue between IF and ID.
// Flags come only from the occupancy count; flush and reset empty the queue.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pcplus8,
  output logic             id_adel,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc_d    [DEPTH];
  logic             adel_q  [DEPTH];
  logic             adel_d  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = count_q == CNT_FULL;
  assign id_valid = count_q != '0;
  assign count    = count_q;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && id_valid;

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    adel_d   = adel_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        instr_d[wr_ptr_q] = if_instr;
        pc_d[wr_ptr_q]    = if_pc;
        adel_d[wr_ptr_q]  = |if_pc[1:0];
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Push and pop together leave the count alone.
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        adel_q[i]  <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      adel_q   <= adel_d;
    end
  end

  assign id_instr   = id_valid ? instr_q[rd_ptr_q] : '0;
  assign id_pc      = id_valid ? pc_q[rd_ptr_q] : '0;
  assign id_pcplus8 = id_valid ? pc_q[rd_ptr_q] + 32'd8 : '0;
  assign id_adel    = id_valid && adel_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: queue-model scoreboard plus directed literal checks.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        pop = 1'b0;
  logic        flush = 1'b0;
  logic        full, id_valid, id_adel;
  logic [31:0] id_instr, id_pc, id_pcplus8;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mq[$];

  fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .push(push), .if_instr(if_instr),
    .if_pc(if_pc), .pop(pop), .flush(flush), .full(full),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pcplus8(id_pcplus8), .id_adel(id_adel), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference queue: flush/reset empty it, pop and push judged on pre-edge size.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      automatic int  sz = mq.size();
      automatic bit  do_push = push && sz < 4;
      automatic bit  do_pop = pop && sz > 0;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({if_instr, if_pc});
    end
  end

  always @(negedge clk) begin
    automatic logic [31:0] ei = '0;
    automatic logic [31:0] ep = '0;
    automatic logic [31:0] e8 = '0;
    automatic logic        ea = 1'b0;
    if (mq.size() > 0) begin
      ei = mq[0][63:32];
      ep = mq[0][31:0];
      e8 = ep + 32'd8;
      ea = ep[1:0] != 2'b00;
    end
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_full", 32'(full), 32'(mq.size() == 4));
    chk("m_valid", 32'(id_valid), 32'(mq.size() != 0));
    chk("m_instr", id_instr, ei);
    chk("m_pc", id_pc, ep);
    chk("m_pc8", id_pcplus8, e8);
    chk("m_adel", 32'(id_adel), 32'(ea));
  end

  task automatic drive(input logic p, input logic [31:0] ins,
                       input logic [31:0] pc, input logic po,
                       input logic fl);
    push = p;
    if_instr = ins;
    if_pc = pc;
    pop = po;
    flush = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pop_empty_cnt", 32'(count), 32'd0);

    drive(1'b1, 32'h2408_0005, 32'h0000_3000, 1'b0, 1'b0);
    idle();
    chk("one_valid", 32'(id_valid), 32'd1);
    chk("one_instr", id_instr, 32'h2408_0005);
    chk("one_pc", id_pc, 32'h0000_3000);
    chk("one_pc8", id_pcplus8, 32'h0000_3008);
    chk("one_count", 32'(count), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("one_pop_valid", 32'(id_valid), 32'd0);
    chk("one_pop_count", 32'(count), 32'd0);

    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'h2000_0000 + 32'(i), 32'h3000 + 32'(4*i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    drive(1'b1, 32'hdead_beef, 32'h3010, 1'b0, 1'b0);
    chk("ovf_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", id_pc, 32'h3000 + 32'(4*i));
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain_count", 32'(count), 32'd0);

    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h3000_0000 + 32'(i), 32'h4000 + 32'(4*i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_pc", id_pc, 32'h4000 + 32'(4*i));
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    drive(1'b1, 32'h5000_0000, 32'h5000, 1'b0, 1'b0);
    drive(1'b1, 32'h5000_0001, 32'h5004, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("pp_head", id_pc, 32'h5000 + 32'(4*i));
      drive(1'b1, 32'h5000_0002 + 32'(i), 32'h5008 + 32'(4*i), 1'b1, 1'b0);
      chk("pp_count", 32'(count), 32'd2);
    end
    chk("pp_after", id_pc, 32'h500C);
    drive(1'b1, 32'h5000_0005, 32'h5014, 1'b0, 1'b0);
    drive(1'b1, 32'h5000_0006, 32'h5018, 1'b0, 1'b0);
    chk("pp_full", 32'(full), 32'd1);
    drive(1'b1, 32'h5000_0007, 32'h5020, 1'b1, 1'b0);
    chk("pp_full_cnt", 32'(count), 32'd3);
    chk("pp_full_head", id_pc, 32'h5010);

    drive(1'b1, 32'h6666_6666, 32'h5030, 1'b1, 1'b1);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(id_valid), 32'd0);
    drive(1'b1, 32'h6000_0000, 32'h6000, 1'b0, 1'b0);
    chk("fl_next_pc", id_pc, 32'h6000);
    chk("fl_next_cnt", 32'(count), 32'd1);

    drive(1'b1, 32'h6000_0001, 32'h0000_3002, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("adel_pc", id_pc, 32'h3002);
    chk("adel_flag", 32'(id_adel), 32'd1);
    drive(1'b1, 32'h7000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0);
    chk("wrap8_pc8", id_pcplus8, 32'h0000_0004);
    chk("wrap8_adel", 32'(id_adel), 32'd0);
    drive(1'b1, 32'h7000_0001, 32'h6008, 1'b0, 1'b0);
    chk("ar_pre_cnt", 32'(count), 32'd2);

    #2 reset = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_valid", 32'(id_valid), 32'd0);
    chk("ar_pc", id_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'h8000_0000, 32'h8000, 1'b0, 1'b0);
    chk("post_rst_pc", id_pc, 32'h8000);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
